chaos_stream_decryptor: RTL and testbench
=========================================

Name: chaos_stream_decryptor

Overview:
- Streaming, multi-channel successor to the array-based image decryptor; consumes one cipher pixel per channel per beat over valid/ready and emits plaintext.
- Each channel runs its own fixed-point logistic-map keystream (r = 4), seeded from the 128-bit key, with a warm-up phase, pixel chaining and a per-frame pixel counter.
- Sits between the pixel DMA/stream source and the image writer.

Parameters:
- CHANNELS, 3, number of colour planes decrypted in parallel.
- PIX_W, 8, pixel width in bits; legal range 1..16.
- WARMUP, 16, number of discarded map iterations after a key load; 0 is legal.
- CNT_W, 20, width of the frame pixel counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse: latch the config inputs and (re)start.
- cfg_key  in  128  key K.
- cfg_depth  in  5  bit depth F.
- cfg_frame_pixels  in  CNT_W  beats per frame; 0 is treated as 2^CNT_W.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_sof  in  1  start-of-frame marker on the input beat.
- s_data  in  CHANNELS*PIX_W  cipher pixels; channel c sits at [c*PIX_W +: PIX_W].
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_data  out  CHANNELS*PIX_W  plaintext pixels, same channel packing as s_data.
- m_eof  out  1  marks the last beat of a frame.
- busy  out  1  high in WARMUP or RUN.
- err_sync  out  1  sticky flag: s_sof seen mid-frame.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_eof=0, busy=0, err_sync=0, s_ready=0. State = IDLE, all registers cleared.
- FSM states are IDLE, WARMUP and RUN.
  - IDLE: s_ready=0. On cfg_start, latch key/depth/frame_pixels, seed the channels, clear counter/err_sync/m_valid, load prev. Go to WARMUP, or straight to RUN if WARMUP=0.
  - WARMUP: s_ready=0. Each cycle, every channel does x<=f(x) and a warm-up counter increments. After exactly WARMUP cycles, go to RUN.
  - RUN: s_ready = !m_valid | m_ready (one-entry output register, full throughput).
  - cfg_start in any state restarts as described for IDLE; it has priority over a simultaneous beat, which is dropped, and the pending output is discarded.
- Seeding: S = K[31:0]^K[63:32]^K[95:64]^K[127:96]. seed_c = S ^ (c*32'h9E3779B9 mod 2^32). If seed_c is 0, use 32'h0000_0001.
- Map: x is unsigned Q0.32. p = x*(2^32 - x), computed in 64 bits. f(x) = p>>30, saturated to 32'hFFFF_FFFF when the result is 2^32.
- Chaining register: prev_c loads K[127 -: PIX_W] on every start and on every s_sof beat.
- Per accepted beat, per channel:
  - ks = x_c[31 -: PIX_W].
  - plain = (C_c ^ ks ^ prev_c) & mask, with mask = (1<<F)-1. F=0 or F>PIX_W uses all ones.
  - Then x_c<=f(x_c) and prev_c<=C_c (raw, unmasked cipher).
  - The keystream is continuous across frames and is reset only by cfg_start.
- Latency: 1 cycle from accept to m_valid. m_data and m_eof hold while m_valid & !m_ready.
- Frame counter:
  - Increments per accepted beat.
  - m_eof=1 on the beat where count == frame_pixels-1; the counter then wraps to 0.
  - s_sof with count==0 is normal.
  - s_sof with count!=0: set err_sync, reset the counter to 0 before counting this beat, reload prev (this beat is counted as beat 0).
- rst mid-operation: return to the reset values immediately. No output beat survives reset.

Test Plan:
- WARMUP=0, CHANNELS=1, PIX_W=8, K=0, F=8: start, send C=0x00 then C=0x00 -> plain 0x00 (x=1, ks=0x00), then x=3. Second output 0x00; x becomes f(3)=0x0000000B.
- Saturation: set K so that S=32'h8000_0000, WARMUP=0 -> ch0 ks first beat 0x80, second beat 0xFF (x=FFFF_FFFF), third beat 0x00 (x=3).
- Backpressure: hold m_ready=0 for 5 cycles with a steady s_valid -> exactly one beat captured, s_ready=0, m_data stable. Release -> one beat per cycle with no loss or duplication.
- Framing: frame_pixels=4, 8 beats with s_sof on beats 0 and 4 -> m_eof on outputs 3 and 7, err_sync=0. s_sof on beat 2 -> err_sync=1 and m_eof moves to beat 5.
- Warm-up: WARMUP=16 -> s_ready stays 0 for 16 cycles after cfg_start, busy=1. The first keystream equals the 16th iterate of the seed (checked against the reference model).
- Depth and restart: F=4 -> upper bits of m_data are 0. cfg_start mid-stream with m_valid=1 -> m_valid drops next cycle and the keystream restarts from the seed.

Source files
------------

// File: rtl/chaos_stream_decryptor.sv
// Multi-channel streaming decryptor: each channel XORs its cipher pixel with a
// logistic-map keystream byte and the previous raw cipher pixel.
module chaos_stream_decryptor #(
  parameter int CHANNELS = 3,
  parameter int PIX_W    = 8,
  parameter int WARMUP   = 16,
  parameter int CNT_W    = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [127:0]              cfg_key,
  input  logic [4:0]                cfg_depth,
  input  logic [CNT_W-1:0]          cfg_frame_pixels,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      s_sof,
  input  logic [CHANNELS*PIX_W-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CHANNELS*PIX_W-1:0] m_data,
  output logic                      m_eof,
  output logic                      busy,
  output logic                      err_sync
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  // One r=4 logistic step in Q0.32; only x = 2^31 reaches 2^32 and is saturated.
  function automatic logic [31:0] map_f(input logic [31:0] x);
    logic [63:0] p;
    logic [33:0] r;
    p = {32'd0, x} * (64'h1_0000_0000 - {32'd0, x});
    r = 34'(p >> 30);
    map_f = (r[33:32] != 2'd0) ? 32'hFFFF_FFFF : r[31:0];
  endfunction

  logic [1:0]                      state_q, state_d;
  logic [WARM_W-1:0]               warm_q, warm_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [CNT_W-1:0]                frame_q, frame_d;
  logic [4:0]                      depth_q, depth_d;
  logic [PIX_W-1:0]                prev_init_q, prev_init_d;
  logic [CHANNELS-1:0][31:0]       x_q, x_d;
  logic [CHANNELS-1:0][PIX_W-1:0]  prev_q, prev_d;
  logic                            m_valid_q, m_valid_d;
  logic [CHANNELS*PIX_W-1:0]       m_data_q, m_data_d;
  logic                            m_eof_q, m_eof_d;
  logic                            err_sync_q, err_sync_d;

  logic                            ready_c;
  logic                            accept;
  logic [PIX_W-1:0]                mask;
  logic [31:0]                     key_fold;
  logic [31:0]                     seed;
  logic [CNT_W-1:0]                cnt_eff;
  logic                            eof_hit;

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    count_d     = count_q;
    frame_d     = frame_q;
    depth_d     = depth_q;
    prev_init_d = prev_init_q;
    x_d         = x_q;
    prev_d      = prev_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_eof_d     = m_eof_q;
    err_sync_d  = err_sync_q;
    seed        = 32'd0;
    key_fold    = cfg_key[31:0] ^ cfg_key[63:32] ^ cfg_key[95:64] ^ cfg_key[127:96];

    ready_c = (state_q == ST_RUN) && (!m_valid_q || m_ready);
    accept  = s_valid && ready_c && !cfg_start;

    if ((depth_q == 5'd0) || (depth_q > 5'(PIX_W))) mask = {PIX_W{1'b1}};
    else                                             mask = ~({PIX_W{1'b1}} << depth_q);

    // A mid-frame s_sof realigns the counter so that this beat becomes beat 0.
    cnt_eff = (s_sof && (count_q != '0)) ? '0 : count_q;
    eof_hit = (cnt_eff == frame_q - CNT_W'(1));

    if (cfg_start) begin
      for (int c = 0; c < CHANNELS; c++) begin
        seed = key_fold ^ (32'(c) * 32'h9E37_79B9);
        x_d[c]    = (seed == 32'd0) ? 32'h0000_0001 : seed;
        prev_d[c] = cfg_key[127 -: PIX_W];
      end
      prev_init_d = cfg_key[127 -: PIX_W];
      depth_d     = cfg_depth;
      frame_d     = cfg_frame_pixels;
      count_d     = '0;
      warm_d      = '0;
      err_sync_d  = 1'b0;
      m_valid_d   = 1'b0;
      m_eof_d     = 1'b0;
      state_d     = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          for (int c = 0; c < CHANNELS; c++) x_d[c] = map_f(x_q[c]);
          warm_d = warm_q + WARM_W'(1);
          if (warm_q == WARM_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (m_valid_q && m_ready) m_valid_d = 1'b0;
          if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
              m_data_d[c*PIX_W +: PIX_W] = (s_data[c*PIX_W +: PIX_W] ^ x_q[c][31 -: PIX_W] ^
                                            (s_sof ? prev_init_q : prev_q[c])) & mask;
              x_d[c]    = map_f(x_q[c]);
              prev_d[c] = s_data[c*PIX_W +: PIX_W];
            end
            m_valid_d = 1'b1;
            m_eof_d   = eof_hit;
            count_d   = eof_hit ? '0 : cnt_eff + CNT_W'(1);
            if (s_sof && (count_q != '0)) err_sync_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      warm_q      <= '0;
      count_q     <= '0;
      frame_q     <= '0;
      depth_q     <= '0;
      prev_init_q <= '0;
      x_q         <= '0;
      prev_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_eof_q     <= 1'b0;
      err_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      depth_q     <= depth_d;
      prev_init_q <= prev_init_d;
      x_q         <= x_d;
      prev_q      <= prev_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_eof_q     <= m_eof_d;
      err_sync_q  <= err_sync_d;
    end
  end

  assign s_ready  = ready_c;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_eof    = m_eof_q;
  assign busy     = (state_q != ST_IDLE);
  assign err_sync = err_sync_q;

endmodule

// File: tb/tb_chaos_stream_decryptor.sv
// Bench for chaos_stream_decryptor: a 3-channel WARMUP=16 instance checked against a
// behavioural model, plus a 1-channel WARMUP=0 instance for hand-computed vectors.
module tb_chaos_stream_decryptor;

  localparam int CH = 3;
  localparam int PW = 8;
  localparam int WU = 16;
  localparam int CW = 20;
  localparam int DW = CH * PW;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_start;
  logic [127:0]   cfg_key;
  logic [4:0]     cfg_depth;
  logic [CW-1:0]  cfg_frame_pixels;
  logic           s_valid, s_ready, s_sof;
  logic [DW-1:0]  s_data;
  logic           m_valid, m_ready, m_eof, busy, err_sync;
  logic [DW-1:0]  m_data;

  logic           z_cfg_start;
  logic [127:0]   z_cfg_key;
  logic [4:0]     z_cfg_depth;
  logic [CW-1:0]  z_cfg_frame;
  logic           z_s_valid, z_s_ready, z_s_sof;
  logic [7:0]     z_s_data;
  logic           z_m_valid, z_m_ready, z_m_eof, z_busy, z_err_sync;
  logic [7:0]     z_m_data;

  always #5 clk = ~clk;

  chaos_stream_decryptor #(.CHANNELS(CH), .PIX_W(PW), .WARMUP(WU), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_depth(cfg_depth),
    .cfg_frame_pixels(cfg_frame_pixels), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_eof(m_eof),
    .busy(busy), .err_sync(err_sync)
  );

  chaos_stream_decryptor #(.CHANNELS(1), .PIX_W(8), .WARMUP(0), .CNT_W(CW)) dut_z (
    .clk(clk), .rst(rst), .cfg_start(z_cfg_start), .cfg_key(z_cfg_key), .cfg_depth(z_cfg_depth),
    .cfg_frame_pixels(z_cfg_frame), .s_valid(z_s_valid), .s_ready(z_s_ready), .s_sof(z_s_sof),
    .s_data(z_s_data), .m_valid(z_m_valid), .m_ready(z_m_ready), .m_data(z_m_data), .m_eof(z_m_eof),
    .busy(z_busy), .err_sync(z_err_sync)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]   mx [CH];
  logic [PW-1:0] mprev [CH];
  logic [PW-1:0] mkp;
  longint        mcount, mframe;
  logic [4:0]    mdepth;
  logic          merr;
  logic [DW-1:0] exp_data_q [$];
  logic          exp_eof_q [$];

  logic          acc, out_fire, out_eof_s, rdy_s;
  logic [DW-1:0] out_data_s;
  logic [DW-1:0] ed;
  logic          ee;

  // Logistic map from its arithmetic definition: x*(2^32-x)/2^30 with saturation.
  function automatic logic [31:0] ref_map(input logic [31:0] x);
    longint unsigned xx, p, y;
    xx = {32'd0, x};
    p  = xx * (64'd4294967296 - xx);
    y  = p / 64'd1073741824;
    if (y >= 64'd4294967296) return 32'hFFFF_FFFF;
    return y[31:0];
  endfunction

  task automatic model_start(input logic [127:0] key, input logic [4:0] depth, input logic [CW-1:0] frame);
    logic [31:0] s, seed;
    longint unsigned g;
    s = key[31:0] ^ key[63:32] ^ key[95:64] ^ key[127:96];
    for (int c = 0; c < CH; c++) begin
      g = longint'(c) * 64'h9E3779B9;
      seed = s ^ g[31:0];
      mx[c] = (seed == 0) ? 32'd1 : seed;
      for (int w = 0; w < WU; w++) mx[c] = ref_map(mx[c]);
      mprev[c] = key[127 -: PW];
    end
    mkp    = key[127 -: PW];
    mcount = 0;
    mframe = (frame == 0) ? (longint'(1) << CW) : longint'(frame);
    mdepth = depth;
    merr   = 1'b0;
    exp_data_q.delete();
    exp_eof_q.delete();
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic sof);
    logic [DW-1:0] pd;
    logic [31:0]   t;
    logic [PW-1:0] ks, cc, mk;
    int unsigned   mki;
    logic          eof;
    if (sof) begin
      if (mcount != 0) merr = 1'b1;
      mcount = 0;
      for (int c = 0; c < CH; c++) mprev[c] = mkp;
    end
    mki = (mdepth == 0 || mdepth > PW) ? ((1 << PW) - 1) : ((1 << mdepth) - 1);
    mk  = mki[PW-1:0];
    for (int c = 0; c < CH; c++) begin
      t  = mx[c] >> (32 - PW);
      ks = t[PW-1:0];
      cc = d[c*PW +: PW];
      pd[c*PW +: PW] = (cc ^ ks ^ mprev[c]) & mk;
      mx[c]    = ref_map(mx[c]);
      mprev[c] = cc;
    end
    eof    = (mcount == mframe - 1);
    mcount = eof ? 0 : mcount + 1;
    exp_data_q.push_back(pd);
    exp_eof_q.push_back(eof);
  endtask

  // Drive one cycle, record the handshakes that the coming edge will complete.
  task automatic step(input logic sv, input logic [DW-1:0] d, input logic sof, input logic mr);
    s_valid = sv; s_data = d; s_sof = sof; m_ready = mr;
    #1;
    rdy_s      = s_ready;
    acc        = s_valid && s_ready && !cfg_start;
    out_fire   = m_valid && m_ready;
    out_data_s = m_data;
    out_eof_s  = m_eof;
    if (acc) model_beat(d, sof);
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [127:0] key, input logic [4:0] depth, input logic [CW-1:0] frame);
    cfg_key = key; cfg_depth = depth; cfg_frame_pixels = frame;
    cfg_start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    model_start(key, depth, frame);
  endtask

  task automatic wait_run();
    int n = 0;
    m_ready = 1'b1; s_valid = 1'b0;
    while (!s_ready && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (!s_ready) begin errors++; $display("[TB] FAIL wait_run s_ready=%b required 1 within 40 cycles", s_ready); end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    checks++;
    if ({m_valid, m_data, m_eof, busy, err_sync, s_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset got valid=%b data=%h eof=%b busy=%b err=%b rdy=%b required all 0",
               m_valid, m_data, m_eof, busy, err_sync, s_ready);
    end
  endtask

  task automatic test_zero_map();
    logic [7:0] cin [7];
    logic [7:0] cexp [7];
    cin  = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    cexp = '{8'h00, 8'h00, 8'h5A, 8'h5A, 8'h80, 8'hFF, 8'h00};
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || i == 4) begin
        z_cfg_key = (i == 0) ? 128'd0 : {96'd0, 32'h8000_0000};
        z_cfg_start = 1'b1;
        @(posedge clk); #1;
        z_cfg_start = 1'b0;
        checks++;
        if (z_s_ready !== 1'b1 || z_busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL zero_warmup_run got rdy=%b busy=%b required 1/1", z_s_ready, z_busy);
        end
      end
      z_s_valid = 1'b1; z_s_data = cin[i];
      @(posedge clk); #1;
      z_s_valid = 1'b0;
      checks++;
      if (z_m_valid !== 1'b1 || z_m_data !== cexp[i]) begin
        errors++;
        $display("[TB] FAIL zero_map beat %0d got valid=%b data=%h required 1/%h", i, z_m_valid, z_m_data, cexp[i]);
      end
    end
  endtask

  task automatic test_warmup();
    do_start(rand_key(), 5'd8, 20'd0);
    for (int i = 0; i < WU; i++) begin
      #1;
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL warmup cycle %0d got rdy=%b busy=%b required 0/1", i, s_ready, busy);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL warmup_end got rdy=%b required 1", s_ready); end
    for (int i = 0; i < 6; i++) begin
      step(i < 4, DW'({$urandom, $urandom}), 1'b0, 1'b1);
      if (out_fire) begin
        ed = exp_data_q.pop_front(); ee = exp_eof_q.pop_front(); checks++;
        if (out_data_s !== ed) begin errors++; $display("[TB] FAIL warmup_data got %h required %h", out_data_s, ed); end
      end
    end
  endtask

  task automatic test_random_stream();
    logic sof;
    do_start(rand_key(), 5'd8, 20'd5);
    wait_run();
    for (int i = 0; i < 320; i++) begin
      sof = (mcount == 0) || ($urandom_range(0, 39) == 0);
      step((i < 300) && ($urandom_range(0, 3) != 0), DW'({$urandom, $urandom}), sof,
           (i >= 300) || ($urandom_range(0, 3) != 0));
      if (out_fire) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++; $display("[TB] FAIL random_extra got %h required no output", out_data_s);
        end else begin
          ed = exp_data_q.pop_front(); ee = exp_eof_q.pop_front();
          if (out_data_s !== ed || out_eof_s !== ee) begin
            errors++; $display("[TB] FAIL random_beat got %h/%b required %h/%b", out_data_s, out_eof_s, ed, ee);
          end
        end
      end
    end
    checks++;
    if (exp_data_q.size() != 0 || err_sync !== merr) begin
      errors++; $display("[TB] FAIL random_end got left=%0d err=%b required 0/%b", exp_data_q.size(), err_sync, merr);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    int accs, outs;
    do_start(rand_key(), 5'd8, 20'd0);
    wait_run();
    step(1'b1, DW'({$urandom, $urandom}), 1'b0, 1'b0);
    accs = acc ? 1 : 0;
    held = m_data;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'({$urandom, $urandom}), 1'b0, 1'b0);
      if (acc) accs++;
      checks++;
      if (rdy_s !== 1'b0 || m_valid !== 1'b1 || out_data_s !== held) begin
        errors++; $display("[TB] FAIL backpressure_hold got rdy=%b data=%h required 0/%h", rdy_s, out_data_s, held);
      end
    end
    checks++;
    if (accs != 1) begin errors++; $display("[TB] FAIL backpressure_accepts got %0d required 1", accs); end
    outs = 0;
    for (int i = 0; i < 20; i++) begin
      step(i < 16, DW'({$urandom, $urandom}), 1'b0, 1'b1);
      if (out_fire) begin
        outs++; ed = exp_data_q.pop_front(); ee = exp_eof_q.pop_front(); checks++;
        if (out_data_s !== ed) begin errors++; $display("[TB] FAIL backpressure_data got %h required %h", out_data_s, ed); end
      end
    end
    checks++;
    if (outs != 17) begin errors++; $display("[TB] FAIL backpressure_count got %0d required 17", outs); end
  endtask

  task automatic test_framing();
    int k, sof2, eof_at1, eof_at2;
    for (int pass = 0; pass < 2; pass++) begin
      sof2    = (pass == 0) ? 4 : 2;
      eof_at1 = (pass == 0) ? 3 : 5;
      eof_at2 = (pass == 0) ? 7 : 5;
      do_start(rand_key(), 5'd8, 20'd4);
      wait_run();
      k = 0;
      for (int i = 0; i < 10; i++) begin
        step(i < 8, DW'({$urandom, $urandom}), (i == 0) || (i == sof2), 1'b1);
        if (out_fire) begin
          ed = exp_data_q.pop_front(); ee = exp_eof_q.pop_front(); checks++;
          if (out_data_s !== ed || out_eof_s !== ((k == eof_at1) || (k == eof_at2))) begin
            errors++; $display("[TB] FAIL framing pass %0d out %0d got %h/%b required %h/%b",
                               pass, k, out_data_s, out_eof_s, ed, (k == eof_at1) || (k == eof_at2));
          end
          k++;
        end
      end
      checks++;
      if (err_sync !== (pass == 1)) begin
        errors++; $display("[TB] FAIL framing_err pass %0d got %b required %b", pass, err_sync, pass == 1);
      end
    end
  endtask

  task automatic test_depth_restart();
    logic [127:0] key;
    key = rand_key();
    do_start(key, 5'd4, 20'd0);
    wait_run();
    for (int i = 0; i < 12; i++) begin
      step(i < 10, DW'({$urandom, $urandom}), 1'b0, 1'b1);
      if (out_fire) begin
        ed = exp_data_q.pop_front(); ee = exp_eof_q.pop_front(); checks++;
        if (out_data_s !== ed) begin errors++; $display("[TB] FAIL depth_data got %h required %h", out_data_s, ed); end
        for (int c = 0; c < CH; c++) begin
          checks++;
          if (out_data_s[c*PW+4 +: 4] !== 4'h0) begin
            errors++; $display("[TB] FAIL depth_upper ch %0d got %h required 0", c, out_data_s[c*PW+4 +: 4]);
          end
        end
      end
    end
    step(1'b1, DW'({$urandom, $urandom}), 1'b0, 1'b0);
    step(1'b1, DW'({$urandom, $urandom}), 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL restart_pending got valid=%b required 1", m_valid); end
    cfg_start = 1'b1; s_valid = 1'b1; m_ready = 1'b0; cfg_depth = 5'd4;
    @(posedge clk); #1;
    cfg_start = 1'b0; s_valid = 1'b0;
    model_start(key, 5'd4, 20'd0);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_drop got valid=%b required 0", m_valid); end
    wait_run();
    for (int i = 0; i < 6; i++) begin
      step(i < 4, DW'({$urandom, $urandom}), 1'b0, 1'b1);
      if (out_fire) begin
        ed = exp_data_q.pop_front(); ee = exp_eof_q.pop_front(); checks++;
        if (out_data_s !== ed) begin errors++; $display("[TB] FAIL restart_data got %h required %h", out_data_s, ed); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start(rand_key(), 5'd8, 20'd3);
    wait_run();
    step(1'b1, DW'({$urandom, $urandom}) | DW'(1), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({m_valid, m_data, m_eof, busy, err_sync, s_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid got valid=%b data=%h eof=%b busy=%b err=%b rdy=%b required all 0",
               m_valid, m_data, m_eof, busy, err_sync, s_ready);
    end
    rst = 1'b0;
    exp_data_q.delete(); exp_eof_q.delete();
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_key = '0; cfg_depth = 5'd8; cfg_frame_pixels = '0;
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b1;
    z_cfg_start = 1'b0; z_cfg_key = '0; z_cfg_depth = 5'd8; z_cfg_frame = '0;
    z_s_valid = 1'b0; z_s_sof = 1'b0; z_s_data = '0; z_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_zero_map();
    test_warmup();
    test_random_stream();
    test_backpressure();
    test_framing();
    test_depth_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
